// File: rtl/game_pkg.sv
// Constants shared by the whack-a-mole game blocks (FSM, timer, display).
// The BCD helper is only used at elaboration time to form load values.
package game_pkg;

   localparam int CLK_HZ_DEFAULT       = 100_000_000;
   localparam int GAME_SECONDS_DEFAULT = 30;
   localparam int SECS_W               = 7;
   localparam int BCD_W                = 4;

   function automatic logic [2*BCD_W-1:0] to_bcd(input int value);
      int tens;
      int ones;
      tens = value / 10;
      ones = value % 10;
      return {tens[BCD_W-1:0], ones[BCD_W-1:0]};
   endfunction

endpackage

// File: rtl/game_timer_bcd_down_counter.sv
// Two-digit loadable BCD down-counter; holds at 00 instead of wrapping.
module bcd_down_counter
   import game_pkg::*;
#(
   parameter logic [BCD_W-1:0] RESET_TENS = 4'd0,
   parameter logic [BCD_W-1:0] RESET_ONES = 4'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BCD_W-1:0] load_tens,
   input  logic [BCD_W-1:0] load_ones,
   input  logic             dec,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic             zero
);

   logic [BCD_W-1:0] tens_q, tens_d;
   logic [BCD_W-1:0] ones_q, ones_d;
   logic             zero_s;

   assign zero_s = (tens_q == {BCD_W{1'b0}}) && (ones_q == {BCD_W{1'b0}});

   // Next digit values: load beats decrement; borrow from tens when ones is 0.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (load) begin
         tens_d = load_tens;
         ones_d = load_ones;
      end else if (dec && !zero_s) begin
         if (ones_q == {BCD_W{1'b0}}) begin
            ones_d = BCD_W'(9);
            tens_d = tens_q - BCD_W'(1);
         end else begin
            ones_d = ones_q - BCD_W'(1);
         end
      end else begin
         tens_d = tens_q;
         ones_d = ones_q;
      end
   end

   // Digit registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tens_q <= RESET_TENS;
         ones_q <= RESET_ONES;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;
   assign zero = zero_s;

endmodule

// File: rtl/game_timer.sv
// Round countdown timer: prescaler, seconds count (binary + BCD), expiry and
// last-seconds warning. sys_reset reloads a fresh round.
module game_timer
   import game_pkg::*;
#(
   parameter int CLK_HZ       = CLK_HZ_DEFAULT,
   parameter int GAME_SECONDS = GAME_SECONDS_DEFAULT,
   parameter int WARN_SECONDS = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sys_reset,
   input  logic              game_active,
   output logic              game_time_up,
   output logic              sec_tick,
   output logic [SECS_W-1:0] secs_left,
   output logic [BCD_W-1:0]  secs_tens,
   output logic [BCD_W-1:0]  secs_ones,
   output logic              warn
);

   localparam int                  PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRESC_W-1:0]  PRESC_TC  = PRESC_W'(CLK_HZ - 1);
   localparam logic [SECS_W-1:0]   SECS_LOAD = SECS_W'(GAME_SECONDS);
   localparam logic [SECS_W-1:0]   WARN_V    = SECS_W'(WARN_SECONDS);
   localparam logic [2*BCD_W-1:0]  LOAD_BCD  = to_bcd(GAME_SECONDS);
   localparam logic [BCD_W-1:0]    LOAD_TENS = LOAD_BCD[2*BCD_W-1:BCD_W];
   localparam logic [BCD_W-1:0]    LOAD_ONES = LOAD_BCD[BCD_W-1:0];

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [SECS_W-1:0]  secs_q, secs_d;
   logic               time_up_q, time_up_d;
   logic               tick_q, tick_d;
   logic               warn_q, warn_d;
   logic               run_s;
   logic               tc_s;
   logic               bcd_zero_s;

   // The BCD zero flag also blocks counting, so the count can never wrap.
   assign run_s = game_active && !time_up_q && !sys_reset && !bcd_zero_s;
   assign tc_s  = run_s && (presc_q == PRESC_TC);

   // Next-state for prescaler, seconds, expiry, tick and warning.
   always_comb begin
      presc_d   = presc_q;
      secs_d    = secs_q;
      time_up_d = time_up_q;
      tick_d    = 1'b0;
      warn_d    = 1'b0;
      if (sys_reset) begin
         presc_d   = {PRESC_W{1'b0}};
         secs_d    = SECS_LOAD;
         time_up_d = 1'b0;
      end else begin
         if (run_s) begin
            presc_d = tc_s ? {PRESC_W{1'b0}} : (presc_q + PRESC_W'(1));
         end else begin
            presc_d = presc_q;
         end
         if (tc_s) begin
            secs_d = secs_q - SECS_W'(1);
            tick_d = 1'b1;
            if (secs_q == SECS_W'(1)) begin
               time_up_d = 1'b1;
            end else begin
               time_up_d = time_up_q;
            end
         end else begin
            secs_d = secs_q;
         end
         // Warn tracks the value secs_left will show, so it lines up with the display.
         warn_d = (WARN_SECONDS > 0) && game_active &&
                  (secs_d != {SECS_W{1'b0}}) && (secs_d <= WARN_V);
      end
   end

   // Timer state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q   <= {PRESC_W{1'b0}};
         secs_q    <= SECS_LOAD;
         time_up_q <= 1'b0;
         tick_q    <= 1'b0;
         warn_q    <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         secs_q    <= secs_d;
         time_up_q <= time_up_d;
         tick_q    <= tick_d;
         warn_q    <= warn_d;
      end
   end

   bcd_down_counter #(
      .RESET_TENS (LOAD_TENS),
      .RESET_ONES (LOAD_ONES)
   ) u_bcd (
      .clk       (clk),
      .reset     (reset),
      .load      (sys_reset),
      .load_tens (LOAD_TENS),
      .load_ones (LOAD_ONES),
      .dec       (tc_s),
      .tens      (secs_tens),
      .ones      (secs_ones),
      .zero      (bcd_zero_s)
   );

   assign game_time_up = time_up_q;
   assign sec_tick     = tick_q;
   assign secs_left    = secs_q;
   assign warn         = warn_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: a 10-Hz/3-second instance for control and
// expiry behaviour, and a 4-Hz/20-second instance for BCD borrow sequencing.
module tb_game_timer;

   logic       clk;
   logic       reset;
   logic       sys_reset_a, game_active_a;
   logic       sys_reset_b, game_active_b;
   logic       up_a, tick_a, warn_a;
   logic [6:0] secs_a;
   logic [3:0] tens_a, ones_a;
   logic       up_b, tick_b, warn_b;
   logic [6:0] secs_b;
   logic [3:0] tens_b, ones_b;

   int compared;
   int mismatched;
   int act_a;

   game_timer #(.CLK_HZ(10), .GAME_SECONDS(3), .WARN_SECONDS(2)) dut_a (
      .clk(clk), .reset(reset), .sys_reset(sys_reset_a), .game_active(game_active_a),
      .game_time_up(up_a), .sec_tick(tick_a), .secs_left(secs_a),
      .secs_tens(tens_a), .secs_ones(ones_a), .warn(warn_a)
   );

   game_timer #(.CLK_HZ(4), .GAME_SECONDS(20), .WARN_SECONDS(2)) dut_b (
      .clk(clk), .reset(reset), .sys_reset(sys_reset_b), .game_active(game_active_b),
      .game_time_up(up_b), .sec_tick(tick_b), .secs_left(secs_b),
      .secs_tens(tens_b), .secs_ones(ones_b), .warn(warn_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {up, tick, warn, secs[7], tens[4], ones[4], presc[4]}
   function automatic logic [21:0] obs_a();
      return {up_a, tick_a, warn_a, secs_a, tens_a, ones_a, dut_a.presc_q};
   endfunction

   task automatic run_phase_a(input int n, input bit active, input string name);
      bit          ticked;
      int          s;
      logic [21:0] exp_v;
      game_active_a = active;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         ticked = 1'b0;
         if (active && act_a < 30) begin
            act_a++;
            ticked = (act_a % 10 == 0);
         end
         s = 3 - act_a / 10;
         exp_v = {act_a >= 30, ticked, active && s >= 1 && s <= 2,
                  7'(s), 4'(s / 10), 4'(s % 10), 4'(act_a % 10)};
         compared++;
         if (obs_a() !== exp_v) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %h expected %h (up,tick,warn,secs,tens,ones,presc)",
                     name, i, obs_a(), exp_v);
         end
      end
   endtask

   task automatic do_sys_reset_a(input bit active, input string name);
      logic [21:0] exp_v;
      exp_v = {1'b0, 1'b0, 1'b0, 7'd3, 4'd0, 4'd3, 4'd0};
      game_active_a = active;
      sys_reset_a   = 1'b1;
      @(posedge clk); #1;
      sys_reset_a   = 1'b0;
      act_a         = 0;
      compared++;
      if (obs_a() !== exp_v) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, obs_a(), exp_v);
      end
   endtask

   task automatic test_reset();
      logic [21:0] exp_v;
      logic [18:0] exp_b;
      exp_v = {1'b0, 1'b0, 1'b0, 7'd3, 4'd0, 4'd3, 4'd0};
      exp_b = {1'b0, 1'b0, 1'b0, 7'd20, 4'd2, 4'd0};
      #2 reset = 1'b1;
      #1;
      compared++;
      if (obs_a() !== exp_v) begin
         mismatched++;
         $display("FAIL reset_a: got %h expected %h", obs_a(), exp_v);
      end
      compared++;
      if ({up_b, tick_b, warn_b, secs_b, tens_b, ones_b} !== exp_b) begin
         mismatched++;
         $display("FAIL reset_b: got %h expected %h",
                  {up_b, tick_b, warn_b, secs_b, tens_b, ones_b}, exp_b);
      end
      #19 reset = 1'b0;
      act_a = 0;
   endtask

   task automatic test_run();
      run_phase_a(35, 1'b1, "run_continuous");
   endtask

   task automatic test_sys_reset();
      do_sys_reset_a(1'b0, "sys_reset_idle");
      run_phase_a(3, 1'b0, "after_reload_idle");
   endtask

   task automatic test_pause();
      run_phase_a(15, 1'b1, "pause_pre");
      run_phase_a(40, 1'b0, "pause_hold");
      run_phase_a(15, 1'b1, "pause_resume");
   endtask

   task automatic test_sys_reset_on_tc();
      do_sys_reset_a(1'b0, "reload_before_collide");
      run_phase_a(29, 1'b1, "collide_pre");
      do_sys_reset_a(1'b1, "collide_reload");
      run_phase_a(12, 1'b0, "collide_after");
   endtask

   task automatic test_bcd();
      int          s;
      logic [18:0] exp_b;
      game_active_b = 1'b1;
      for (int k = 1; k <= 44; k++) begin
         @(posedge clk); #1;
         s = 20 - k / 4;
         exp_b = {1'b0, (k % 4 == 0), 1'b0, 7'(s), 4'(s / 10), 4'(s % 10)};
         compared++;
         if ({up_b, tick_b, warn_b, secs_b, tens_b, ones_b} !== exp_b) begin
            mismatched++;
            $display("FAIL bcd_seq k=%0d: got %h expected %h",
                     k, {up_b, tick_b, warn_b, secs_b, tens_b, ones_b}, exp_b);
         end
         compared++;
         if (32'(tens_b) * 10 + 32'(ones_b) !== 32'(secs_b)) begin
            mismatched++;
            $display("FAIL bcd_agree k=%0d: bcd %0d%0d binary %0d", k, tens_b, ones_b, secs_b);
         end
      end
      compared++;
      if ({tens_b, ones_b} !== 8'h09) begin
         mismatched++;
         $display("FAIL bcd_final: got %h expected 09", {tens_b, ones_b});
      end
      game_active_b = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [21:0] exp_v;
      exp_v = {1'b0, 1'b0, 1'b0, 7'd3, 4'd0, 4'd3, 4'd0};
      run_phase_a(17, 1'b1, "async_pre");
      #3 reset = 1'b1;
      #1;
      compared++;
      if (obs_a() !== exp_v) begin
         mismatched++;
         $display("FAIL async_reset: got %h expected %h", obs_a(), exp_v);
      end
      game_active_a = 1'b0;
      #2 reset = 1'b0;
      act_a = 0;
      run_phase_a(3, 1'b0, "async_after");
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      act_a         = 0;
      reset         = 1'b0;
      sys_reset_a   = 1'b0;
      game_active_a = 1'b0;
      sys_reset_b   = 1'b0;
      game_active_b = 1'b0;
      test_reset();
      test_run();
      test_sys_reset();
      test_pause();
      test_sys_reset_on_tc();
      test_bcd();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
